// File: rtl/regfile_param_if.sv
// Register-file access bundle: write port, NRD read ports, debug read port and status.
// master drives addresses and write data; slave (the register file) drives the read side.
interface regfile_param_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned NRD   = 2
);
  localparam int unsigned AW = $clog2(NREGS);

  logic                 we;
  logic [AW-1:0]        wr_addr;
  logic [XLEN-1:0]      wr_data;
  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD*XLEN-1:0]  rd_data;
  logic [AW-1:0]        dbg_addr;
  logic [XLEN-1:0]      dbg_data;
  logic                 ready;
  logic                 wr_err;

  modport master (
    output we, wr_addr, wr_data, rd_addr, dbg_addr,
    input  rd_data, dbg_data, ready, wr_err
  );

  modport slave (
    input  we, wr_addr, wr_data, rd_addr, dbg_addr,
    output rd_data, dbg_data, ready, wr_err
  );
endinterface

// File: rtl/regfile_param.sv
// Parametrised register file: NREGS x XLEN, NRD combinational read ports, one write port,
// registered debug read port. After reset a sequencer clears one entry per cycle (loading
// SP_INIT into SP_IDX) before accepting writes; writes attempted meanwhile pulse wr_err.
// Entry 0 always reads as zero.
// Optional feature: define REGS_BYPASS_EN to forward same-cycle write data to read ports.
module regfile_param #(
  parameter int unsigned     XLEN    = 32,
  parameter int unsigned     NREGS   = 32,
  parameter int unsigned     NRD     = 2,
  parameter int unsigned     SP_IDX  = 2,
  parameter logic [XLEN-1:0] SP_INIT = XLEN'(32'h700)
) (
  input logic             clk,
  input logic             rst,
  regfile_param_if.slave  bus
);
  localparam int unsigned AW = $clog2(NREGS);
  // idx is one bit wider than an address so the terminal compare never wraps
  localparam logic [AW:0] SpIdx   = (AW+1)'(SP_IDX);
  localparam logic [AW:0] LastIdx = (AW+1)'(NREGS - 1);

  typedef enum logic {StClear, StRun} state_e;

  state_e          state_q, state_d;
  logic [AW:0]     idx_q, idx_d;
  logic            wr_err_q, wr_err_d;
  logic [XLEN-1:0] dbg_q, dbg_d;
  logic [XLEN-1:0] mem_q [NREGS];
  logic            ready;

  assign ready        = (state_q == StRun);
  assign bus.ready    = ready;
  assign bus.wr_err   = wr_err_q;
  assign bus.dbg_data = dbg_q;

  // Next-state logic for the init sequencer, error pulse and debug read
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    wr_err_d = 1'b0;
    dbg_d    = '0;
    if (state_q == StClear) begin
      idx_d = idx_q + (AW+1)'(1);
      if (idx_q == LastIdx) begin
        state_d = StRun;
      end
      // writes to x0 are ignored anyway, so they are not reported as dropped
      wr_err_d = bus.we && (bus.wr_addr != '0);
    end
    // reads the stored value, so a same-cycle write shows up one cycle later
    if (ready && (bus.dbg_addr != '0)) begin
      dbg_d = mem_q[bus.dbg_addr];
    end
  end

  // Control and status registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StClear;
      idx_q    <= '0;
      wr_err_q <= 1'b0;
      dbg_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      wr_err_q <= wr_err_d;
      dbg_q    <= dbg_d;
    end
  end

  // Storage: cleared by the sequencer, then written from the write port
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == StClear) begin
        mem_q[idx_q[AW-1:0]] <= (idx_q == SpIdx) ? SP_INIT : '0;
      end else if (bus.we && (bus.wr_addr != '0)) begin
        mem_q[bus.wr_addr] <= bus.wr_data;
      end
    end
  end

  // Combinational read ports; all zero until the clear sequence completes
  always_comb begin
    bus.rd_data = '0;
    for (int k = 0; k < NRD; k++) begin
      if (ready && (bus.rd_addr[k*AW +: AW] != '0)) begin
`ifdef REGS_BYPASS_EN
        if (bus.we && (bus.wr_addr == bus.rd_addr[k*AW +: AW])) begin
          bus.rd_data[k*XLEN +: XLEN] = bus.wr_data;
        end else begin
          bus.rd_data[k*XLEN +: XLEN] = mem_q[bus.rd_addr[k*AW +: AW]];
        end
`else
        bus.rd_data[k*XLEN +: XLEN] = mem_q[bus.rd_addr[k*AW +: AW]];
`endif
      end
    end
  end
endmodule

// File: tb/tb_regfile_param.sv
// Scoreboard bench for regfile_param: stimulus pushes expected values, a negedge monitor
// pops and compares them against the selected DUT output.
module tb_regfile_param #(
  parameter int unsigned     XLEN    = 32,
  parameter int unsigned     NREGS   = 32,
  parameter int unsigned     NRD     = 2,
  parameter logic [XLEN-1:0] SP_INIT = XLEN'(32'h700)
);
  localparam int unsigned AW = $clog2(NREGS);
  localparam int SelDbg   = 100;
  localparam int SelReady = 101;
  localparam int SelErr   = 102;

  typedef struct {
    string       name;
    int          sel;
    logic [63:0] exp;
  } chk_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  chk_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  regfile_param_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus ();

  regfile_param #(
    .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .SP_IDX(2), .SP_INIT(SP_INIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic logic [63:0] actual(input int sel);
    logic [63:0] v;
    v = '0;
    if (sel == SelDbg) v[XLEN-1:0] = bus.dbg_data;
    else if (sel == SelReady) v[0] = bus.ready;
    else if (sel == SelErr) v[0] = bus.wr_err;
    else v[XLEN-1:0] = bus.rd_data[sel*XLEN +: XLEN];
    return v;
  endfunction

  // Monitor: compares every queued expectation at the falling edge
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      chk_t c;
      logic [63:0] a;
      c = sb.pop_front();
      a = actual(c.sel);
      checks++;
      if (a !== c.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", c.name, a, c.exp);
      end
    end
  end

  task automatic expect_val(input string name, input int sel, input logic [63:0] exp);
    chk_t c;
    c.name = name;
    c.sel  = sel;
    c.exp  = exp;
    sb.push_back(c);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int k, input logic [AW-1:0] a);
    bus.rd_addr[k*AW +: AW] = a;
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [63:0] d);
    bus.we      = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d[XLEN-1:0];
  endtask

  // One reset cycle, then the reset state is checked before rst drops
  task automatic do_reset();
    rst    = 1'b1;
    bus.we = 1'b0;
    tick();
    expect_val("reset_ready", SelReady, 64'd0);
    expect_val("reset_wr_err", SelErr, 64'd0);
    expect_val("reset_dbg", SelDbg, 64'd0);
    rst = 1'b0;
  endtask

  // ready must stay low until exactly NREGS posedges after rst dropped
  task automatic wait_ready_exact(input int already);
    for (int i = already; i < NREGS; i++) begin
      expect_val("ready_low", SelReady, 64'd0);
      tick();
    end
    expect_val("ready_high", SelReady, 64'd1);
  endtask

  initial begin
    bus.we       = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.rd_addr  = '0;
    bus.dbg_addr = '0;

    // 1. reset and init contents
    do_reset();
    wait_ready_exact(0);
    set_rd(0, AW'(2));
    set_rd(NRD - 1, AW'(1));
    expect_val("init_sp", 0, 64'(SP_INIT));
    expect_val("init_r1", NRD - 1, 64'd0);
    tick();
    set_rd(0, AW'(NREGS - 1));
    expect_val("init_rlast", 0, 64'd0);
    tick();

    // 2. write then read on every port, debug read one cycle later
    write(AW'(5), 64'hDEADBEEF);
    tick();
    bus.we = 1'b0;
    for (int k = 0; k < NRD; k++) begin
      set_rd(k, AW'(5));
      expect_val("rd_same_addr", k, 64'hDEADBEEF);
    end
    bus.dbg_addr = AW'(5);
    tick();
    expect_val("dbg_read", SelDbg, 64'hDEADBEEF);
    // debug shows the pre-write value when the same entry is written that cycle
    write(AW'(5), 64'h11);
    tick();
    expect_val("dbg_prewrite", SelDbg, 64'hDEADBEEF);
    bus.we = 1'b0;
    expect_val("rd_after_overwrite", 0, 64'h11);
    tick();
    expect_val("dbg_new_value", SelDbg, 64'h11);

    // 3. x0 stays zero and never flags an error
    write(AW'(0), 64'h12345678);
    tick();
    bus.we = 1'b0;
    set_rd(0, AW'(0));
    expect_val("x0_read", 0, 64'd0);
    expect_val("x0_no_err", SelErr, 64'd0);
    bus.dbg_addr = AW'(0);
    tick();
    expect_val("x0_dbg", SelDbg, 64'd0);

    // 4. write during clear is dropped and pulses wr_err
    do_reset();
    tick();
    tick();
    tick();
    set_rd(0, AW'(2));
    expect_val("rd_zero_not_ready", 0, 64'd0);
    write(AW'(3), 64'hAA);
    tick();
    expect_val("clear_wr_err", SelErr, 64'd1);
    write(AW'(0), 64'h77);
    tick();
    expect_val("clear_x0_no_err", SelErr, 64'd0);
    bus.we = 1'b0;
    tick();
    expect_val("err_idle", SelErr, 64'd0);
    wait_ready_exact(6);
    set_rd(0, AW'(3));
    expect_val("dropped_write", 0, 64'd0);
    tick();

    // 5. reset in the middle of the clear sequence
    write(AW'(7), 64'h55);
    tick();
    bus.we = 1'b0;
    set_rd(0, AW'(7));
    expect_val("rd_r7", 0, 64'h55);
    do_reset();
    for (int i = 0; i < 10; i++) tick();
    do_reset();
    wait_ready_exact(0);
    set_rd(0, AW'(7));
    set_rd(NRD - 1, AW'(2));
    expect_val("rerst_r7", 0, 64'd0);
    expect_val("rerst_sp", NRD - 1, 64'(SP_INIT));
    tick();

    // 6. same-cycle write and read of one entry
    write(AW'(9), 64'h1111);
    tick();
    write(AW'(9), 64'hCAFEF00D);
    set_rd(0, AW'(9));
    bus.dbg_addr = AW'(9);
`ifdef REGS_BYPASS_EN
    expect_val("bypass_same_cycle", 0, 64'hCAFEF00D);
`else
    expect_val("no_bypass_same_cycle", 0, 64'h1111);
`endif
    tick();
    bus.we = 1'b0;
    expect_val("bypass_next_cycle", 0, 64'hCAFEF00D);
    expect_val("dbg_never_bypassed", SelDbg, 64'h1111);
    tick();
    tick();

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
